// File: rtl/imem_loader_pkg.sv
// Shared definitions for the program loader and its neighbours (ifetch, imem).
// Holds the loader state encoding, default framing constants and the imem geometry.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int CNT_W = 10;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Handshake: a byte moves on every clk edge where rx_valid && rx_ready; rx_data is only meaningful while rx_valid is high.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_w;
    logic [31:0]       mem_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr_w, mem_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr_w, mem_data
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs data bytes little-endian into 32-bit words and issues a one-cycle write strobe
// the cycle after the fourth byte of each word; address and data hold until the next write.
module imem_loader_word_assembler #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_word_done,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_data
);
    logic [1:0]        r_lane;
    logic [23:0]       r_shift;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;

    assign o_word_done = i_byte_valid && (r_lane == 2'd3);
    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_data      = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_lane <= 2'd0;
            end else if (i_byte_valid) begin
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0: r_shift[7:0]   <= i_byte;
                    2'd1: r_shift[15:8]  <= i_byte;
                    2'd2: r_shift[23:16] <= i_byte;
                    default: begin
                        r_data <= {i_byte, r_shift};
                        r_addr <= i_addr;
                        r_we   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Program loader: parses SYNC/count/data/checksum frames from a host byte link,
// writes the words into instruction memory and holds the CPU until a good frame lands.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = IMEM_ADDR_W,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [ADDR_W:0] words_written,
    output state_t        dbg_state
);
    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_nm1;
    logic [CNT_W-1:0]  r_widx;
    logic [7:0]        r_csum;
    logic [ADDR_W:0]   r_words;

    logic              w_xfer;
    logic              w_is_sync;
    logic              w_start;
    logic              w_data_byte;
    logic              w_word_done;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_addr;

    // Never backpressures: one byte per cycle is always sustainable.
    assign bus.rx_ready = 1'b1;

    assign w_xfer      = bus.rx_valid && bus.rx_ready;
    assign w_is_sync   = (bus.rx_data == SYNC_BYTE);
    assign w_start     = w_xfer && w_is_sync &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_data_byte = w_xfer && (r_state == S_DATA);
    assign w_last_word = w_word_done && (r_widx == r_nm1);
    assign w_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(r_widx);

    assign done          = (r_state == S_DONE);
    assign err           = (r_state == S_ERR);
    assign cpu_hold      = (r_state != S_DONE);
    assign busy          = is_busy(r_state);
    assign words_written = r_words;
    assign dbg_state     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_CNT_LO;
            S_CNT_LO: if (w_xfer) w_next = S_CNT_HI;
            S_CNT_HI: if (w_xfer) w_next = (bus.rx_data[7:2] != 6'd0) ? S_ERR : S_DATA;
            S_DATA:   if (w_last_word) w_next = S_CSUM;
            S_CSUM:   if (w_xfer) w_next = (bus.rx_data == r_csum) ? S_DONE : S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nm1   <= '0;
            r_widx  <= '0;
            r_csum  <= 8'd0;
            r_words <= '0;
        end else begin
            if (w_start) begin
                r_widx  <= '0;
                r_csum  <= 8'd0;
                r_words <= '0;
            end
            if (w_xfer && (r_state == S_CNT_LO)) r_nm1[7:0] <= bus.rx_data;
            if (w_xfer && (r_state == S_CNT_HI)) r_nm1[9:8] <= bus.rx_data[1:0];
            if (w_data_byte) begin
                r_csum <= r_csum + bus.rx_data;
                if (w_word_done) begin
                    r_widx  <= r_widx + 1'b1;
                    r_words <= r_words + 1'b1;
                end
            end
        end
    end

    imem_loader_word_assembler #(
        .ADDR_W (ADDR_W)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_byte_valid (w_data_byte),
        .i_byte       (bus.rx_data),
        .i_addr       (w_addr),
        .o_word_done  (w_word_done),
        .o_we         (bus.mem_we),
        .o_addr       (bus.mem_addr_w),
        .o_data       (bus.mem_data)
    );
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-byte vector table plus multi-cycle sequences
// (gapped 3-word frame, reset mid-frame, 1024-word frame with address wrap).
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct {
        logic [7:0]  b;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        err;
        logic        hold;
        logic [10:0] words;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(10)) bus1 ();
    imem_loader_if #(.ADDR_W(10)) bus2 ();
    assign bus2.rx_data  = bus1.rx_data;
    assign bus2.rx_valid = bus1.rx_valid;

    logic        hold1, busy1, done1, err1, hold2, busy2, done2, err2;
    logic [10:0] ww1, ww2;
    state_t      st1, st2;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1), .cpu_hold(hold1), .busy(busy1),
        .done(done1), .err(err1), .words_written(ww1), .dbg_state(st1)
    );

    imem_loader #(.ADDR_W(10), .BASE_ADDR(10), .SYNC_BYTE(8'hA5)) u_dut_wrap (
        .clk(clk), .rst(rst), .bus(bus2), .cpu_hold(hold2), .busy(busy2),
        .done(done2), .err(err2), .words_written(ww2), .dbg_state(st2)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [9:0]  a1_q[$];
    logic [31:0] d1_q[$];
    logic [9:0]  a2_q[$];
    logic [31:0] d2_q[$];
    logic [41:0] exp_q[$];
    int   cons_cnt = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always @(negedge clk) begin
        if (bus1.mem_we) begin
            a1_q.push_back(bus1.mem_addr_w);
            d1_q.push_back(bus1.mem_data);
        end
        if (bus2.mem_we) begin
            a2_q.push_back(bus2.mem_addr_w);
            d2_q.push_back(bus2.mem_data);
        end
        if ((bus1.mem_we && prev1) || (bus2.mem_we && prev2)) cons_cnt++;
        prev1 = bus1.mem_we;
        prev2 = bus2.mem_we;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        bus1.rx_valid = v;
        bus1.rx_data  = b;
        @(posedge clk);
        #1;
        bus1.rx_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic we, input logic [31:0] data,
                                input logic busy, input logic done, input logic err,
                                input logic hold, input logic [10:0] words);
        vec_t v;
        v.b = b; v.we = we; v.addr = 10'd0; v.data = data;
        v.busy = busy; v.done = done; v.err = err; v.hold = hold; v.words = words;
        return v;
    endfunction

    task automatic check_reset_values(input string name);
        check(name, {bus1.rx_ready, bus1.mem_we, bus1.mem_addr_w, bus1.mem_data,
                     hold1, busy1, done1, err1, ww1},
                    {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0});
    endtask

    task automatic send_frame1();
        logic [7:0] f [8];
        f = '{8'hA5, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        for (int i = 0; i < 8; i++) drive(1'b1, f[i]);
    endtask

    vec_t vt[$];

    initial begin
        int   base1;
        int   base2;
        logic [7:0] sum;
        logic [7:0] g [16];
        logic [41:0] e;

        bus1.rx_valid = 1'b0;
        bus1.rx_data  = 8'h00;
        #3;
        check_reset_values("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle junk, good frame, bad checksum, junk in ERR, good resend, bad count, junk, 2nd good frame
        vt.push_back(mk(8'h00, 0, 32'h0, 0, 0, 0, 1, 0));
        vt.push_back(mk(8'hFF, 0, 32'h0, 0, 0, 0, 1, 0));
        vt.push_back(mk(8'hA5, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h78, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h56, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h34, 0, 32'h0, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h12, 1, 32'h12345678, 1, 0, 0, 1, 1));
        vt.push_back(mk(8'h14, 0, 32'h12345678, 0, 1, 0, 0, 1));
        vt.push_back(mk(8'hA5, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h78, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h56, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h34, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h12, 1, 32'h12345678, 1, 0, 0, 1, 1));
        vt.push_back(mk(8'h15, 0, 32'h12345678, 0, 0, 1, 1, 1));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 0, 0, 1, 1, 1));
        vt.push_back(mk(8'hA5, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h78, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h56, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h34, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h12, 1, 32'h12345678, 1, 0, 0, 1, 1));
        vt.push_back(mk(8'h14, 0, 32'h12345678, 0, 1, 0, 0, 1));
        vt.push_back(mk(8'hA5, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h04, 0, 32'h12345678, 0, 0, 1, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 0, 0, 1, 1, 0));
        vt.push_back(mk(8'hFF, 0, 32'h12345678, 0, 0, 1, 1, 0));
        vt.push_back(mk(8'hA5, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h00, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h01, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h02, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h03, 0, 32'h12345678, 1, 0, 0, 1, 0));
        vt.push_back(mk(8'h04, 1, 32'h04030201, 1, 0, 0, 1, 1));
        vt.push_back(mk(8'h0A, 0, 32'h04030201, 0, 1, 0, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            drive(1'b1, vt[i].b);
            check($sformatf("vec%0d", i),
                  {bus1.mem_we, bus1.mem_addr_w, bus1.mem_data, busy1, done1, err1, hold1, ww1},
                  {vt[i].we, vt[i].addr, vt[i].data, vt[i].busy, vt[i].done, vt[i].err,
                   vt[i].hold, vt[i].words});
        end

        // 3-word frame with a SYNC value inside the data, one idle cycle between bytes
        base1 = a1_q.size();
        exp_q.push_back({10'd0, 32'h44332211});
        exp_q.push_back({10'd1, 32'h887766A5});
        exp_q.push_back({10'd2, 32'h04030201});
        g = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5,
              8'h66, 8'h77, 8'h88, 8'h01, 8'h02, 8'h03, 8'h04, 8'hBE};
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, g[i]);
            drive(1'b0, 8'h00);
        end
        check("gap_write_count", a1_q.size() - base1, 3);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            if (base1 + i < a1_q.size())
                check($sformatf("gap_write%0d", i), {a1_q[base1+i], d1_q[base1+i]}, e);
            else
                check($sformatf("gap_write%0d_missing", i), 1'b0, 1'b1);
        end
        check("gap_status", {done1, err1, hold1, busy1, ww1}, {1'b1, 1'b0, 1'b0, 1'b0, 11'd3});

        // reset two bytes into word 0: immediate return to reset values, no write
        base1 = a1_q.size();
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        rst = 1'b1;
        #1;
        check_reset_values("reset_midframe");
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00);
        check("reset_no_write", a1_q.size() - base1, 0);
        check_reset_values("reset_after_release");
        send_frame1();
        check("reload_count", a1_q.size() - base1, 1);
        if (a1_q.size() > base1)
            check("reload_write", {a1_q[base1], d1_q[base1]}, {10'd0, 32'h12345678});
        check("reload_status", {done1, err1, hold1, ww1}, {1'b1, 1'b0, 1'b0, 11'd1});

        // 1024-word frame, back-to-back bytes; the BASE_ADDR=10 instance must wrap to 9
        base1 = a1_q.size();
        base2 = a2_q.size();
        sum = 8'd0;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h03);
        for (int w = 0; w < 1024; w++) begin
            logic [9:0] wv;
            wv = 10'(w);
            drive(1'b1, wv[7:0]);
            drive(1'b1, {6'd0, wv[9:8]});
            drive(1'b1, 8'h00);
            drive(1'b1, 8'h00);
            sum = sum + wv[7:0] + {6'd0, wv[9:8]};
        end
        drive(1'b1, sum);
        drive(1'b0, 8'h00);
        check("wrap_count_base0", a1_q.size() - base1, 1024);
        check("wrap_count_base10", a2_q.size() - base2, 1024);
        if (a2_q.size() >= base2 + 1024) begin
            check("wrap_first_addr", a2_q[base2], 10'd10);
            check("wrap_last_addr", {a2_q[base2+1023], d2_q[base2+1023]}, {10'd9, 32'h000003FF});
        end
        if (a1_q.size() >= base1 + 1024)
            check("base0_last_addr", {a1_q[base1+1023], d1_q[base1+1023]}, {10'd1023, 32'h000003FF});
        check("wrap_status", {done2, err2, hold2, ww2, done1, ww1},
                             {1'b1, 1'b0, 1'b0, 11'd1024, 1'b1, 11'd1024});
        check("no_consecutive_we", cons_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
